// File: rtl/seq_operand_mux.sv
// seq_operand_mux
//   Registered N-channel operand selector for the matrix multiplier datapath.
//   Direct mode (mode=0): every cycle in IDLE loads the channel chosen by sel.
//   Scan mode (mode=1): a start pulse streams channels 0..last_idx to the MAC
//   stage over a valid/ready handshake. A beat holds while out_ready is low,
//   and done pulses once after the final handshake.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   in_bus        N flattened channels; channel i = in_bus[i*WIDTH +: WIDTH]
//   mode          0 = direct, 1 = scan (sampled only in IDLE)
//   sel           direct-mode channel index
//   start         begins a scan when in IDLE with mode=1
//   last_idx      final scan channel, sampled together with start
//   out_data      registered selected channel
//   out_idx       index of the channel currently in out_data
//   out_valid     out_data/out_idx valid
//   out_ready     consumer accepts the current beat (scan mode only)
//   busy          high while a scan is in progress
//   done          one-cycle pulse after the final scan handshake
//   err           one-cycle pulse on an out-of-range sel or last_idx
//
// Parameters: WIDTH data bits, N channels (2..256), SEL_W with 2**SEL_W >= N.
module seq_operand_mux #(
  parameter int WIDTH = 16,
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               start,
  input  logic [SEL_W-1:0]   last_idx,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam int DEPTH = 1 << SEL_W;
  // N is compared in SEL_W+1 bits so that N == 2**SEL_W still fits.
  localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

  state_t           state;
  logic [SEL_W-1:0] last_q;

  // The channel table is padded out to the full index range so that any
  // SEL_W-bit index addresses a defined entry. Padding entries are never
  // loaded because illegal indices are rejected first.
  logic [WIDTH-1:0] ch [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ch
    if (i < N) begin : g_real
      assign ch[i] = in_bus[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch[i] = '0;
    end
  end

  logic             sel_ok;
  logic             last_ok;
  logic [SEL_W-1:0] next_idx;

  always_comb begin
    sel_ok   = {1'b0, sel} < N_EXT;
    last_ok  = {1'b0, last_idx} < N_EXT;
    next_idx = out_idx + 1'b1;
  end

  // NOTE: all state below is updated with non-blocking assignments, so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_q    <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // done and err are single-cycle pulses.
      done <= 1'b0;
      err  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (!mode) begin
            if (sel_ok) begin
              out_data  <= ch[sel];
              out_idx   <= sel;
              out_valid <= 1'b1;
            end else begin
              out_data  <= '0;
              out_valid <= 1'b0;
              err       <= 1'b1;
            end
          end else if (start) begin
            out_valid <= 1'b0;
            if (!last_ok) begin
              err <= 1'b1;
            end else begin
              last_q    <= last_idx;
              out_data  <= ch[0];
              out_idx   <= '0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= SCAN;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end

        SCAN: begin
          // Without a handshake nothing is reloaded, so a stalled beat keeps
          // the data it captured even if in_bus changes underneath it.
          if (out_valid && out_ready) begin
            if (out_idx == last_q) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_idx  <= next_idx;
              out_data <= ch[next_idx];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_operand_mux.sv
// tb_seq_operand_mux
//   Directed bench for seq_operand_mux. A 16-channel instance covers direct
//   mode, scans with and without backpressure, ignored start/mode during a
//   scan, and async reset mid-scan. A 12-channel instance covers illegal
//   index handling. Channel i is driven with 1<<i.
module tb_seq_operand_mux;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [16*WIDTH-1:0]   in_bus;

  // 16-channel instance
  logic             mode, start, out_ready;
  logic [SEL_W-1:0] sel, last_idx;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_idx;
  logic             out_valid, busy, done, err;

  // 12-channel instance
  logic             mode12, start12, ready12;
  logic [SEL_W-1:0] sel12, last12;
  logic [WIDTH-1:0] data12;
  logic [SEL_W-1:0] idx12;
  logic             valid12, busy12, done12, err12;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  seq_operand_mux #(.WIDTH(WIDTH), .N(16), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .mode(mode), .sel(sel),
    .start(start), .last_idx(last_idx), .out_data(out_data),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  seq_operand_mux #(.WIDTH(WIDTH), .N(12), .SEL_W(SEL_W)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus[12*WIDTH-1:0]), .mode(mode12),
    .sel(sel12), .start(start12), .last_idx(last12), .out_data(data12),
    .out_idx(idx12), .out_valid(valid12), .out_ready(ready12),
    .busy(busy12), .done(done12), .err(err12)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic [SEL_W-1:0] exp_idx;
  } direct_vec_t;

  direct_vec_t dvec [6];

  initial begin
    int  e;
    int  cyc;
    int  busy_cycles;
    int  done_cnt;
    bit  hs;
    bit  finished;

    // Direct-mode vectors: each result appears one cycle after its sel.
    dvec[0] = '{4'd0,  1'b1, 16'h0001, 4'd0};
    dvec[1] = '{4'd1,  1'b1, 16'h0002, 4'd1};
    dvec[2] = '{4'd2,  1'b1, 16'h0004, 4'd2};
    dvec[3] = '{4'd3,  1'b1, 16'h0008, 4'd3};
    dvec[4] = '{4'd15, 1'b1, 16'h8000, 4'd15};
    dvec[5] = '{4'd9,  1'b1, 16'h0200, 4'd9};

    for (int i = 0; i < 16; i++) in_bus[i*WIDTH +: WIDTH] = WIDTH'(1 << i);
    rst_n = 1'b0;
    mode = 1'b0; sel = '0; start = 1'b0; last_idx = '0; out_ready = 1'b0;
    mode12 = 1'b1; sel12 = '0; start12 = 1'b0; last12 = '0; ready12 = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check("rst out_data",  32'(out_data), 32'h0);
    check("rst out_idx",   32'(out_idx), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst busy",      32'(busy), 32'h0);
    check("rst done",      32'(done), 32'h0);
    check("rst err",       32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- direct mode table ----------------
    for (int i = 0; i < 6; i++) begin
      sel = dvec[i].sel;
      step();
      check($sformatf("direct[%0d] valid", i), 32'(out_valid), 32'(dvec[i].exp_valid));
      check($sformatf("direct[%0d] data", i),  32'(out_data),  32'(dvec[i].exp_data));
      check($sformatf("direct[%0d] idx", i),   32'(out_idx),   32'(dvec[i].exp_idx));
      check($sformatf("direct[%0d] err", i),   32'(err),       32'h0);
    end

    // ---------------- scan last_idx=3, ready high ----------------
    mode = 1'b1; start = 1'b1; last_idx = 4'd3; out_ready = 1'b1;
    step();
    start = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("scan3 beat%0d valid", k), 32'(out_valid), 32'h1);
      check($sformatf("scan3 beat%0d idx", k),   32'(out_idx),   32'(k));
      check($sformatf("scan3 beat%0d data", k),  32'(out_data),  32'(1 << k));
      check($sformatf("scan3 beat%0d done", k),  32'(done),      32'h0);
      if (busy) busy_cycles++;
      step();
    end
    check("scan3 done pulse", 32'(done), 32'h1);
    check("scan3 valid end",  32'(out_valid), 32'h0);
    check("scan3 busy end",   32'(busy), 32'h0);
    check("scan3 busy cycles", 32'(busy_cycles), 32'd4);
    step();
    check("scan3 done cleared", 32'(done), 32'h0);

    // ---------------- scan last_idx=15, backpressure 1,0,0,... ----------------
    start = 1'b1; last_idx = 4'd15; out_ready = 1'b0;
    step();
    start = 1'b0;
    check("bp beat0 idx",  32'(out_idx), 32'h0);
    check("bp beat0 data", 32'(out_data), 32'h1);
    e = 0; cyc = 0; finished = 1'b0;
    while (!finished && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      hs = out_ready;
      // Disturb the current channel while its beat is stalled.
      if (e == 5 && !out_ready) in_bus[5*WIDTH +: WIDTH] = 16'hBEEF;
      step();
      if (hs) begin
        if (e == 15) finished = 1'b1;
        else e++;
      end
      if (finished) begin
        check("bp done pulse", 32'(done), 32'h1);
        check("bp valid end",  32'(out_valid), 32'h0);
      end else begin
        check($sformatf("bp c%0d valid", cyc), 32'(out_valid), 32'h1);
        check($sformatf("bp c%0d idx", cyc),   32'(out_idx),   32'(e));
        check($sformatf("bp c%0d data", cyc),  32'(out_data),  32'(1 << e));
        check($sformatf("bp c%0d done", cyc),  32'(done),      32'h0);
      end
      cyc++;
    end
    if (!finished) check("bp timeout", 32'h0, 32'h1);
    check("bp beat count", 32'(e), 32'd15);
    in_bus[5*WIDTH +: WIDTH] = 16'h0020;
    out_ready = 1'b1;
    step();

    // ---------------- start/mode/sel/last_idx ignored during scan ----------------
    mode = 1'b1; start = 1'b1; last_idx = 4'd2;
    step();
    check("ign beat0 idx", 32'(out_idx), 32'h0);
    mode = 1'b0; start = 1'b1; last_idx = 4'd9; sel = 4'd7;
    step();
    check("ign beat1 idx",  32'(out_idx), 32'h1);
    check("ign beat1 data", 32'(out_data), 32'h2);
    mode = 1'b1; start = 1'b1;
    step();
    check("ign beat2 idx",  32'(out_idx), 32'h2);
    check("ign beat2 data", 32'(out_data), 32'h4);
    start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done) done_cnt++;
      if (k == 0) check("ign done first", 32'(done), 32'h1);
    end
    check("ign single done", 32'(done_cnt), 32'h1);
    check("ign idle busy",   32'(busy), 32'h0);

    // ---------------- async reset mid-scan ----------------
    start = 1'b1; last_idx = 4'd15; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("ars pre idx", 32'(out_idx), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    check("ars out_data",  32'(out_data), 32'h0);
    check("ars out_idx",   32'(out_idx), 32'h0);
    check("ars out_valid", 32'(out_valid), 32'h0);
    check("ars busy",      32'(busy), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (done) done_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    if (done) done_cnt++;
    check("ars no done", 32'(done_cnt), 32'h0);
    start = 1'b1; last_idx = 4'd0;
    step();
    start = 1'b0;
    check("ars single valid", 32'(out_valid), 32'h1);
    check("ars single data",  32'(out_data), 32'h1);
    check("ars single busy",  32'(busy), 32'h1);
    step();
    check("ars single done",  32'(done), 32'h1);
    check("ars single valid end", 32'(out_valid), 32'h0);
    check("ars single busy end",  32'(busy), 32'h0);

    // ---------------- N=12 illegal indices ----------------
    mode12 = 1'b0; sel12 = 4'd11;
    step();
    check("n12 sel11 valid", 32'(valid12), 32'h1);
    check("n12 sel11 data",  32'(data12), 32'h0800);
    check("n12 sel11 err",   32'(err12), 32'h0);
    sel12 = 4'd13;
    step();
    check("n12 sel13 err",   32'(err12), 32'h1);
    check("n12 sel13 valid", 32'(valid12), 32'h0);
    check("n12 sel13 data",  32'(data12), 32'h0);
    mode12 = 1'b1; start12 = 1'b1; last12 = 4'd12;
    step();
    check("n12 last12 err",   32'(err12), 32'h1);
    check("n12 last12 busy",  32'(busy12), 32'h0);
    check("n12 last12 valid", 32'(valid12), 32'h0);
    start12 = 1'b0;
    step();
    check("n12 err cleared", 32'(err12), 32'h0);
    check("n12 still idle",  32'(busy12), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/seq_operand_mux.md
Name: seq_operand_mux

Overview:
- Parametrised, registered N-channel operand selector for the matrix multiplier datapath. Generalises the fixed 16:1 x 16-bit combinational mux.
- Direct mode: registered random-access selection.
- Scan mode: streams channels 0..last_idx to the MAC stage over a valid/ready handshake, with backpressure hold and a completion pulse.

Parameters:
- WIDTH, 16, data bits per channel.
- N, 16, number of input channels (2..256).
- SEL_W, 4, index width; must satisfy 2**SEL_W >= N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_bus  input  N*WIDTH  flattened channels; channel i = in_bus[i*WIDTH +: WIDTH]
- mode  input  1  0 = direct, 1 = scan; sampled only in IDLE
- sel  input  SEL_W  channel index for direct mode
- start  input  1  in IDLE with mode=1, begins a scan
- last_idx  input  SEL_W  final channel of scan; sampled with start
- out_data  output  WIDTH  registered selected channel
- out_idx  output  SEL_W  index of the channel in out_data
- out_valid  output  1  out_data/out_idx valid
- out_ready  input  1  consumer accepts (scan mode only)
- busy  output  1  high while in SCAN
- done  output  1  one-cycle pulse after the final scan handshake
- err  output  1  one-cycle pulse on an illegal index

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_data=0, out_idx=0, out_valid=0, busy=0, done=0, err=0. Reset mid-scan aborts immediately; no done pulse is produced.
- States: IDLE, SCAN. done and err are registered one-cycle pulses, default 0.
- IDLE, mode=0 (direct):
  - Each edge loads out_data=ch[sel], out_idx=sel, out_valid=1. Latency 1 cycle.
  - out_ready is ignored in direct mode.
  - If sel >= N: out_data=0, out_valid=0, err=1 for that cycle.
- IDLE, mode=1, start=0: out_valid=0; outputs otherwise hold.
- IDLE, mode=1, start=1:
  - If last_idx >= N: err=1, remain IDLE, out_valid=0.
  - Else: capture last_idx internally, load out_data=ch[0], out_idx=0, out_valid=1, busy=1, go to SCAN. First valid beat appears the cycle after start.
- SCAN, handshake (out_valid & out_ready) at an edge:
  - If out_idx < captured last: out_idx+1, out_data=ch[out_idx+1], out_valid stays 1. Throughput is 1 channel/cycle with out_ready held high.
  - If out_idx == captured last: out_valid=0, busy=0, done=1, return to IDLE.
- SCAN, no handshake: out_data and out_idx hold exactly. Data is sampled once on load; later in_bus changes do not alter a stalled beat.
- In SCAN, start, mode, sel and last_idx are ignored. A new start is only accepted in IDLE, earliest the cycle done is high.
- last_idx=0: single beat, channel 0 only.
- last_idx=N-1: full sweep. out_idx never exceeds N-1 and never wraps.
- Index arithmetic is SEL_W bits. The comparison against N uses SEL_W+1 bits so N = 2**SEL_W is handled.

Test Plan:
- N=16, WIDTH=16, ch[i]=1<<i, mode=0: apply sel=0,1,2,3 on successive cycles -> out_data 0x0001, 0x0002, 0x0004, 0x0008, each one cycle after its sel.
- Scan, last_idx=3, out_ready=1: pulse start -> four consecutive beats with out_idx 0..3 and data 0x0001..0x0008; done=1 the cycle after beat 3; busy 1 for exactly 4 cycles.
- Scan, last_idx=15, out_ready toggled 1,0,0,1,…: each idx is held while out_ready=0. Change ch[idx] during a stall -> out_data keeps the old value. All 16 beats delivered in order, then done.
- N=12, SEL_W=4, mode=0: sel=13 -> err pulse, out_valid=0, out_data=0. mode=1, start with last_idx=12 -> err pulse, busy stays 0.
- Mid-scan at out_idx=5: assert rst_n=0 asynchronously -> all outputs 0 immediately, no done. Release, restart with last_idx=0 -> single beat 0x0001, then done.
- start re-asserted during SCAN and with mode flipped -> ignored: sequence unchanged, exactly one done pulse.
